// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, default width and line idle level.
// Optional parity support is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

    localparam int unsigned DEFAULT_DATA_BITS = 8;
    localparam logic        IDLE_LEVEL        = 1'b1;

    // Frame sequencer states; PARITY exists only in parity-enabled builds
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd5
    } uart_state_t;

`ifdef UART_TX_PARITY_EN
    // Parity over up to 9 data bits (zero-extended); odd=1 inverts to odd parity
    function automatic logic parity_of(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction
`endif

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial-side outputs of the UART transmitter.
interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS
) ();

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx;
    logic                 busy;

    // Producer of bytes (core logic / testbench)
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx,
        input  busy
    );

    // The transmitter itself
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx,
        output busy
    );

endinterface

// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, LSB-first data, optional parity, stop bit(s).
// Bit boundaries are the tick pulses from baud_generator; all outputs registered.
// Parity bit and PARITY state are present only when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      tick,
    uart_tx_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

    uart_state_t          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 accept_c;

`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = ^32'(PARITY_ODD);
`endif

    assign accept_c = bus.tx_valid && ready_q;

    // State and datapath registers; tx returns to idle level asynchronously on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            tx_q     <= IDLE_LEVEL;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state and output logic; every transition after acceptance waits for tick
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        tx_d     = tx_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            IDLE: begin
                // A tick on the acceptance cycle is ignored because we are still IDLE here
                if (accept_c) begin
                    shift_d  = bus.tx_data;
                    cnt_d    = '0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = WAIT;
`ifdef UART_TX_PARITY_EN
                    parity_d = parity_of(9'(bus.tx_data), 1'(PARITY_ODD));
`endif
                end
            end

            WAIT: begin
                if (tick) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end

            START: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = CNT_W'(1);
                    state_d = DATA;
                end
            end

            DATA: begin
                if (tick) begin
                    if (cnt_q < CNT_W'(DATA_BITS)) begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d    = IDLE_LEVEL;
                        cnt_d   = '0;
                        state_d = STOP;
`endif
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    tx_d    = IDLE_LEVEL;
                    cnt_d   = '0;
                    state_d = STOP;
                end
            end
`endif

            STOP: begin
                // cnt counts completed stop bits
                if (tick) begin
                    if (cnt_q == CNT_W'(STOP_BITS - 1)) begin
                        cnt_d   = '0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                tx_d    = IDLE_LEVEL;
                cnt_d   = '0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tx       = tx_q;
    assign bus.tx_ready = ready_q;
    assign bus.busy     = busy_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART serial transmitter: the consumer of the one-cycle `tick` pulses produced by the team's baud_generator.
- Accepts parallel bytes over a valid/ready handshake and shifts out a frame on `tx`, LSB first: start bit, data, optional parity, stop bit(s).
- Each bit lasts exactly one tick interval.
- Sits between the core logic and the UART pin; paired with baud_generator on the same clk.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
STOP_BITS, 1, number of stop bits (1 or 2)
PARITY_ODD, 0, with UART_TX_PARITY_EN: 0 = even parity, 1 = odd parity; ignored otherwise

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
tick  input  1  one-clk pulse per bit period, from baud_generator
tx_data  input  DATA_BITS  byte to send; sampled on acceptance
tx_valid  input  1  tx_data is valid
tx_ready  output  1  registered; high only in IDLE
tx  output  1  serial line, idle high
busy  output  1  high from acceptance until the last stop bit ends

Behaviour:
- Interface (already decided): one clock, clk; reset_n is asynchronous, active-low.
- Reset: state=IDLE, tx=1, tx_ready=1, busy=0, shift register=0, bit counter=0.
- Acceptance:
  - A transfer is accepted on any clk edge with tx_valid && tx_ready.
  - On acceptance, tx_data is latched into the shift register, tx_ready goes to 0 and busy goes to 1 on that same edge; state moves to WAIT.
- WAIT: holds tx=1. On the first tick strictly after the acceptance edge, tx goes to 0 and state moves to START. A tick on the acceptance cycle itself is ignored.
- START: on the next tick, tx drives shift[0], shift register shifts right, counter=1, state moves to DATA.
- DATA:
  - On each tick, if counter < DATA_BITS: tx drives the next bit and counter increments.
  - When counter == DATA_BITS, the next tick ends the last data bit: go to PARITY if enabled, else drive tx=1 and go to STOP.
- PARITY: on the next tick, tx=1 and state moves to STOP.
- STOP:
  - Lasts STOP_BITS tick intervals.
  - On the tick ending the final stop bit: state moves to IDLE, tx_ready goes to 1, busy goes to 0, and tx stays 1.
- Frame timing:
  - Every tx change is registered on a clk edge where tick is 1; no glitches on tx.
  - Frame length = 1 + DATA_BITS + P + STOP_BITS ticks, where P = 1 with parity, else 0.
- Back-to-back frames: tx_ready is 1 on the cycle after the last stop tick. A new acceptance then enters WAIT, so the next start bit begins on the following tick. There is no idle gap beyond the WAIT alignment.
- tx_valid while not ready: ignored, with no side effects. tx_data may change freely.
- tick while IDLE: no effect.
- Reset mid-frame: tx returns to 1 immediately (asynchronously) and the frame is abandoned.
- Counter width: $clog2(DATA_BITS+1) bits.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state exists. The parity bit is the XOR of the data bits, inverted if PARITY_ODD = 1, and is computed at acceptance.
- Undefined: no PARITY state and no parity logic. DATA goes directly to STOP, and PARITY_ODD is unused.

Decomposition:
- Package uart_pkg holds:
  - the state enum/localparams (IDLE, WAIT, START, DATA, PARITY, STOP)
  - the default DATA_BITS
  - the idle line level constant (1'b1)
- Intended for sharing with a future uart_rx.
- No sub-module: uart_tx is a single FSM plus shift register.
- The top level instantiates baud_generator and uart_tx side by side.

Test Plan (baud_generator at CLOCK_FREQ=16000, BAUD_RATE=100, so 160 clk per tick):
- Reset check: hold reset_n=0 for 5 clk, then release -> tx=1, tx_ready=1, busy=0, and tx stays 1 for 2000 clk with no tx_valid.
- Single byte: send 0x55 -> tx bits per tick are 0,1,0,1,0,1,0,1,0,1. Each bit is 160 clk wide. busy falls and tx_ready rises exactly 10 ticks after the start bit began.
- Back-to-back: send 0xA3, with 0x0F held valid immediately after -> two 10-bit frames. The second start bit begins on the tick following the first frame's stop bit. The decoded bytes are 0xA3, 0x0F.
- Busy ignore: pulse tx_valid with 0xFF in the middle of a frame -> the frame is unchanged and no extra frame is sent.
- Reset mid-frame: assert reset_n=0 during data bit 3 -> tx=1 asynchronously. After release, tx_ready=1, and the next byte 0x81 is sent correctly.
- Parity (UART_TX_PARITY_EN, PARITY_ODD=0): send 0x07 -> parity bit 1 and an 11-tick frame. Send 0x03 -> parity bit 0.
